cpu_timing_gen: RTL
===================

Name: cpu_timing_gen

Overview:
- Consumer side of the system clock block. Runs entirely on the 7.095 MHz clock and derives single-cycle clock enables from it, in place of gated or derived clocks.
- Enables produced: Z80 T-state enable (3.5475 MHz, or 7.095 MHz in turbo) and a free-running AY enable (1.77375 MHz).
- Supports whole-T-state stalls for pause (DMA/divmmc) and ULA contention.
- Keeps the frame T-state counter and generates the maskable interrupt pulse at frame start.

Parameters:
- FRAME_T, 70908, T-states per frame; counter wraps FRAME_T-1 -> 0 (69888 for 48K timing).
- INT_LEN, 32, T-states int_n is held low at frame start.
- TW, 17, width of tstate; must satisfy 2^TW >= FRAME_T.

Ports:
- clock70  in  1  7.095 MHz system clock; the only clock in the block.
- reset  in  1  synchronous reset, active-low.
- turbo  in  1  1 = T-state enable every clock70 cycle; 0 = every 2nd cycle.
- pause  in  1  1 = suppress T-state enables (stall CPU).
- contend  in  1  1 = contended access in progress; stall requested (see Optional Feature).
- ce_cpu  out  1  one-cycle T-state enable for the CPU core.
- ce17  out  1  one-cycle 1.77375 MHz enable, free running.
- tstate  out  TW  current T-state within frame.
- int_n  out  1  frame interrupt, active-low.

Behaviour:
- All outputs are registered. While reset=0 at an edge: ph=0, div=0, ce_cpu=0, ce17=0, tstate=0, int_n=1. Reset mid-operation aborts the frame and any stall in that same edge.
- ph is a 1-bit register toggling every clock70 edge; div is a 2-bit register incrementing every edge. Both are unaffected by turbo, pause and contend.
- ce17 <= (div==3). It pulses every 4th cycle and is never stalled.
- Slot: a cycle is a T-state slot when turbo=1, or when turbo=0 and ph==1. Normal-mode slots therefore stay on a fixed 2-cycle grid.
- Stall: stall = pause | contend_eff. contend_eff is contend gated per the Optional Feature and is always 0 when turbo=1.
- At each edge, ce_cpu <= slot & ~stall. Latency from an input change to ce_cpu is one cycle.
- A suppressed slot is lost, not deferred. The next opportunity is the next slot: 1 cycle later in turbo, 2 cycles later in normal mode. Stalls are always whole T-states.
- turbo may change on any cycle and takes effect on the next slot evaluation. After a turbo 1->0 change, the first enable waits for ph==1.
- tstate advances on the same edge that sets ce_cpu=1: tstate <= (tstate==FRAME_T-1) ? 0 : tstate+1. tstate holds during stalls.
- int_n <= ~(tstate < INT_LEN), registered one cycle behind tstate. After reset release, int_n goes low on the 1st cycle and stays low until INT_LEN T-states have elapsed.
- pause and contend both high count as a single stall; there is no priority distinction.
- Arithmetic: TW-bit unsigned. No values outside 0..FRAME_T-1 are reachable.

Optional Feature:
- Macro: CPU_CONTENTION_EN.
- Defined: contend_eff = contend & ~turbo. Each slot sampled with contend=1 is suppressed.
- Undefined: contend_eff = 0. The contend port remains present but is ignored, and timing depends only on turbo and pause.

Test Plan:
- Reset low 5 cycles, then high, turbo=0, pause=0 -> ce_cpu pulses on every 2nd cycle (period 2); ce17 pulses every 4th cycle; tstate increments by 1 per ce_cpu.
- Run 70908 ce_cpu pulses -> tstate wraps 70907->0; int_n low for exactly 32 T-states (64 clock70 cycles), then high until the next wrap.
- pause=1 for 5 cycles, turbo=0 -> 2 or 3 ce_cpu pulses are missing depending on ph alignment; tstate frozen meanwhile; ce17 cadence unchanged; first pulse after release stays on the ph==1 grid.
- turbo=1 -> ce_cpu high on every cycle, tstate +1 per cycle; switch turbo to 0 -> period returns to 2 with no double pulse.
- CPU_CONTENTION_EN defined, turbo=0, contend=1 for 6 cycles -> 3 slots suppressed. Repeat with turbo=1 -> no suppression.
- CPU_CONTENTION_EN undefined, contend=1 held -> ce_cpu identical to contend=0. Also assert reset mid-frame (tstate=1234) -> next edge tstate=0, int_n=1, ce_cpu=0.

Source files
------------

// File: rtl/cpu_timing_gen.sv
// -----------------------------------------------------------------------------
// cpu_timing_gen
//
// Purpose:
//   Consumer side of the system clock block. Everything runs on the 7.095 MHz
//   clock70. Instead of gating or dividing clocks, the block produces
//   single-cycle clock enables:
//     - ce_cpu : Z80 T-state enable. It runs at 3.5475 MHz, or at 7.095 MHz
//                in turbo mode, and can be stalled by whole T-states.
//     - ce17   : free-running 1.77375 MHz enable, used by the AY sound chip.
//   The block also keeps the T-state counter for the video frame and drives
//   the maskable interrupt (int_n) low for the first INT_LEN T-states of
//   each frame.
//
// Optional feature (macro CPU_CONTENTION_EN):
//   Defined   : contend stalls normal-mode T-state slots (ULA contention).
//               It has no effect in turbo mode.
//   Undefined : the contend port is present but ignored.
//
// Parameters:
//   FRAME_T  T-states per frame. The counter wraps from FRAME_T-1 to 0.
//   INT_LEN  Number of T-states that int_n is held low at frame start.
//   TW       Width of tstate. Must satisfy 2^TW >= FRAME_T.
//
// Ports:
//   clock70  in   7.095 MHz system clock (the only clock in this block)
//   reset    in   synchronous reset, active-low
//   turbo    in   1 = T-state slot on every cycle; 0 = slot on every 2nd cycle
//   pause    in   1 = suppress T-state enables (DMA/divmmc stall)
//   contend  in   1 = contended access in progress (see optional feature)
//   ce_cpu   out  one-cycle T-state enable for the CPU core
//   ce17     out  one-cycle 1.77375 MHz enable, never stalled
//   tstate   out  current T-state within the frame
//   int_n    out  frame interrupt, active-low
// -----------------------------------------------------------------------------
module cpu_timing_gen #(
    parameter int FRAME_T = 70908,
    parameter int INT_LEN = 32,
    parameter int TW      = 17
) (
    input  logic          clock70,
    input  logic          reset,
    input  logic          turbo,
    input  logic          pause,
    input  logic          contend,
    output logic          ce_cpu,
    output logic          ce17,
    output logic [TW-1:0] tstate,
    output logic          int_n
);

    localparam logic [TW-1:0] LAST_T   = TW'(FRAME_T - 1);
    localparam logic [TW-1:0] INT_T    = TW'(INT_LEN);
    localparam logic [TW-1:0] TS_ONE   = TW'(1);

    logic          ph_r;
    logic [1:0]    div_r;
    logic          ce_cpu_r;
    logic          ce17_r;
    logic [TW-1:0] tstate_r;
    logic          int_n_r;

    logic          contend_eff_s;
    logic          slot_s;
    logic          stall_s;
    logic          adv_s;
    logic [TW-1:0] tstate_next_s;

    // Contention gating. Turbo mode is never contended.
    always_comb begin
        contend_eff_s = 1'b0;
`ifdef CPU_CONTENTION_EN
        contend_eff_s = contend & ~turbo;
`else
        // The port stays on the interface but cannot stall the CPU.
        contend_eff_s = contend & 1'b0;
`endif
    end

    // Slot, stall, and advance decisions, plus the next value of the frame counter.
    always_comb begin
        // Normal-mode slots stay on the ph==1 grid. This keeps a lost slot
        // from being made up half a T-state later.
        slot_s  = turbo | ph_r;
        stall_s = pause | contend_eff_s;
        adv_s   = slot_s & ~stall_s;
        if (tstate_r == LAST_T) begin
            tstate_next_s = '0;
        end else begin
            tstate_next_s = tstate_r + TS_ONE;
        end
    end

    // All timing state: phase and divider, the enables, the frame counter, and the interrupt.
    always_ff @(posedge clock70) begin
        if (!reset) begin
            ph_r     <= 1'b0;
            div_r    <= 2'd0;
            ce_cpu_r <= 1'b0;
            ce17_r   <= 1'b0;
            tstate_r <= '0;
            int_n_r  <= 1'b1;
        end else begin
            ph_r     <= ~ph_r;
            div_r    <= div_r + 2'd1;
            ce17_r   <= (div_r == 2'd3);
            ce_cpu_r <= adv_s;
            if (adv_s) begin
                tstate_r <= tstate_next_s;
            end else begin
                tstate_r <= tstate_r;
            end
            // int_n is derived from the registered count, so it lags tstate by one cycle.
            int_n_r  <= ~(tstate_r < INT_T);
        end
    end

    assign ce_cpu = ce_cpu_r;
    assign ce17   = ce17_r;
    assign tstate = tstate_r;
    assign int_n  = int_n_r;

endmodule
